ahb_tty_ctrl: RTL

AHB-Lite slave console controller that replaces the bare write-only console address with a buffered, flow-controlled serial transmitter. CPU byte writes are queued in a small TX FIFO and serialised as 8N1 frames on `TXD` at a programmable bit period. The block sits on the AHB-Lite bus beside the RAM, decoded at base `0x40000000`. It provides zero-wait-state register reads and stalls writes with `HREADYOUT` only when the FIFO is full.

---
 rtl/ahb_tty_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/ahb_tty_ctrl.sv
// ahb_tty_ctrl: AHB-Lite console transmitter.
// CPU writes to DATA are queued in a TX FIFO and sent on TXD as 8N1 frames
// with a bit period set by CTRL. Reads never wait. A DATA write stalls only
// while the FIFO is full.
//
// Handshake: a bus transfer is offered (valid) when HSEL & HTRANS[1] & HREADY
// is seen at a posedge, and its data phase completes (ready) on the first
// posedge with HREADYOUT high. Inside the block, a FIFO push happens only
// when the FIFO is not full, and a pop happens only when it is not empty.
module ahb_tty_ctrl #(
  parameter int          FIFO_LOG2 = 3,
  parameter logic [15:0] DIV_RESET = 16'd16
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        TXD,
  output logic        TX_BUSY,
  output logic        TX_IRQ,
  output logic [1:0]  tx_state_dbg
);

  localparam int DEPTH = 1 << FIFO_LOG2;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;

  // Bus data-phase tracking
  logic       dphase, d_write;
  logic [1:0] d_addr;
  logic       addr_phase, push, ctrl_wr;

  // Control register
  logic [15:0] ctrl_div, eff_div;
  logic        irq_en;

  // FIFO
  logic [7:0]         mem [DEPTH];
  logic [FIFO_LOG2:0] wr_ptr, rd_ptr, fifo_count;
  logic               fifo_full, fifo_empty, pop;
  logic [7:0]         fifo_head;
  logic [3:0]         count4;

  // Transmitter
  tx_state_t   state, state_nxt;
  logic [15:0] cnt, cnt_nxt, cur_div, cur_div_nxt;
  logic [2:0]  bit_idx, bit_idx_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        txd_nxt, period_end, shifter_busy;

  logic unused_ok;
  assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:17]};

  assign addr_phase = HSEL & HTRANS[1] & HREADY;
  assign HREADYOUT  = ~(dphase & d_write & (d_addr == 2'd0) & fifo_full);
  assign push       = dphase & d_write & (d_addr == 2'd0) & ~fifo_full;
  assign ctrl_wr    = dphase & d_write & (d_addr == 2'd2);
  assign HRESP      = 1'b0;

  // Capture the address phase; drop the data phase once it completes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dphase  <= 1'b0;
      d_write <= 1'b0;
      d_addr  <= 2'd0;
    end else if (addr_phase) begin
      dphase  <= 1'b1;
      d_write <= HWRITE;
      d_addr  <= HADDR[3:2];
    end else if (HREADYOUT) begin
      dphase  <= 1'b0;
    end
  end

  // CTRL register: divisor and interrupt enable
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_div <= DIV_RESET;
      irq_en   <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_div <= HWDATA[15:0];
      irq_en   <= HWDATA[16];
    end
  end

  // Divisors below 2 cannot produce a sensible bit period, so clamp them
  assign eff_div = (ctrl_div < 16'd2) ? 16'd2 : ctrl_div;

  // FIFO pointers; the extra MSB separates full from empty
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr[FIFO_LOG2-1:0]] <= HWDATA[7:0];
  end

  assign fifo_head  = mem[rd_ptr[FIFO_LOG2-1:0]];
  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                      (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
  assign count4     = 4'(fifo_count);

  // Transmitter state and shifter registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      cur_div <= 16'd2;
      bit_idx <= '0;
      shift   <= '0;
      TXD     <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cur_div <= cur_div_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      TXD     <= txd_nxt;
    end
  end

  assign period_end = (cnt == cur_div - 16'd1);

  // Transmitter next state: start, 8 data bits LSB first, stop; chain frames
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + 16'd1;
    cur_div_nxt = cur_div;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    txd_nxt     = TXD;
    pop         = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        txd_nxt = 1'b1;
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_nxt   = fifo_head;
          cur_div_nxt = eff_div;
          bit_idx_nxt = '0;
          state_nxt   = ST_START;
          txd_nxt     = 1'b0;
        end
      end
      ST_START: begin
        if (period_end) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = ST_DATA;
          txd_nxt     = shift[0];
        end
      end
      ST_DATA: begin
        if (period_end) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = ST_STOP;
            txd_nxt   = 1'b1;
          end else begin
            shift_nxt   = {1'b0, shift[7:1]};
            bit_idx_nxt = bit_idx + 3'd1;
            txd_nxt     = shift[1];
          end
        end
      end
      ST_STOP: begin
        if (period_end) begin
          cnt_nxt = '0;
          if (!fifo_empty) begin
            pop         = 1'b1;
            shift_nxt   = fifo_head;
            cur_div_nxt = eff_div;
            bit_idx_nxt = '0;
            state_nxt   = ST_START;
            txd_nxt     = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
            txd_nxt   = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        txd_nxt   = 1'b1;
      end
    endcase
  end

  assign shifter_busy = (state != ST_IDLE);
  assign TX_BUSY      = ~fifo_empty | shifter_busy;
  assign TX_IRQ       = irq_en & fifo_empty & ~shifter_busy;
  assign tx_state_dbg = state;

  // Read mux, live only during a read data phase
  always_comb begin
    HRDATA = '0;
    if (dphase && !d_write) begin
      case (d_addr)
        2'd1:    HRDATA = {24'd0, count4, 1'b0, shifter_busy, fifo_empty, fifo_full};
        2'd2:    HRDATA = {15'd0, irq_en, ctrl_div};
        default: HRDATA = '0;
      endcase
    end
  end

endmodule
